// File: rtl/gray_rptr_decoder_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : gray_rptr_decoder_if                                            |
// | Brief    : Read-side pointer bundle between the FIFO reader and the        |
// |            gray_rptr_decoder block.                                        |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface gray_rptr_decoder_if #(
   parameter int ADDR_BITS = 4
);
   localparam int c_ptr_w = ADDR_BITS + 1;

   logic [c_ptr_w-1:0]   wptr_gray_i;
   logic                 rd_en_i;
   logic                 rd_ack_o;
   logic [ADDR_BITS-1:0] raddr_o;
   logic [c_ptr_w-1:0]   rptr_bin_o;
   logic [c_ptr_w-1:0]   rptr_gray_o;
   logic [c_ptr_w-1:0]   wptr_bin_o;
   logic                 empty_o;
   logic [c_ptr_w-1:0]   level_o;
   logic                 underflow_o;

   // Reader / write-pointer source side.
   modport master (
      output wptr_gray_i,
      output rd_en_i,
      input  rd_ack_o,
      input  raddr_o,
      input  rptr_bin_o,
      input  rptr_gray_o,
      input  wptr_bin_o,
      input  empty_o,
      input  level_o,
      input  underflow_o
   );

   // Pointer controller side.
   modport slave (
      input  wptr_gray_i,
      input  rd_en_i,
      output rd_ack_o,
      output raddr_o,
      output rptr_bin_o,
      output rptr_gray_o,
      output wptr_bin_o,
      output empty_o,
      output level_o,
      output underflow_o
   );
endinterface
`default_nettype wire

// File: rtl/gray_rptr_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : gray_rptr_decoder                                               |
// | Brief    : Async-FIFO read-side pointer controller: synchronises and       |
// |            decodes the Gray write pointer, owns the read pointer, and      |
// |            produces empty/level. Optional sticky underflow flag enabled    |
// |            by defining GRAY_RPTR_UNDERFLOW_FLAG_EN.                         |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module gray_rptr_decoder #(
   parameter int ADDR_BITS   = 4,
   parameter int SYNC_STAGES = 2    // must be >= 2
) (
   input  wire logic          clk_i,
   input  wire logic          rst_i,
   gray_rptr_decoder_if.slave bus
);
   localparam int c_ptr_w = ADDR_BITS + 1;

   logic [c_ptr_w-1:0] r_sync [SYNC_STAGES];
   logic [c_ptr_w-1:0] w_wgray_s;
   logic [c_ptr_w-1:0] w_wbin_dec;
   logic [c_ptr_w-1:0] r_wptr_bin;
   logic [c_ptr_w-1:0] r_rptr_bin;
   logic [c_ptr_w-1:0] r_rptr_gray;
   logic [c_ptr_w-1:0] w_rbin_next;
   logic [c_ptr_w-1:0] w_rgray_next;
   logic [c_ptr_w-1:0] r_level;
   logic               r_empty;
   logic               w_rd_ack;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            r_sync[i] <= '0;
         end
      end else begin
         r_sync[0] <= bus.wptr_gray_i;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            r_sync[i] <= r_sync[i-1];
         end
      end
   end

   assign w_wgray_s = r_sync[SYNC_STAGES-1];

   // Each binary bit is the XOR of all Gray bits at or above it.
   always_comb begin
      w_wbin_dec = '0;
      for (int i = 0; i < c_ptr_w; i++) begin
         w_wbin_dec[i] = ^(w_wgray_s >> i);
      end
   end

   assign w_rd_ack     = bus.rd_en_i & ~r_empty;
   assign w_rbin_next  = r_rptr_bin + {{(c_ptr_w-1){1'b0}}, w_rd_ack};
   assign w_rgray_next = w_rbin_next ^ (w_rbin_next >> 1);

   // Empty/level compare against the pre-edge write pointer, so fresh
   // write data is seen one cycle after it is decoded.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_wptr_bin  <= '0;
         r_rptr_bin  <= '0;
         r_rptr_gray <= '0;
         r_empty     <= 1'b1;
         r_level     <= '0;
      end else begin
         r_wptr_bin  <= w_wbin_dec;
         r_rptr_bin  <= w_rbin_next;
         r_rptr_gray <= w_rgray_next;
         r_empty     <= (w_rbin_next == r_wptr_bin);
         r_level     <= r_wptr_bin - w_rbin_next;
      end
   end

`ifdef GRAY_RPTR_UNDERFLOW_FLAG_EN
   logic r_underflow;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_underflow <= 1'b0;
      end else if (bus.rd_en_i && r_empty) begin
         r_underflow <= 1'b1;
      end
   end

   assign bus.underflow_o = r_underflow;
`else
   assign bus.underflow_o = 1'b0;
`endif

   assign bus.rd_ack_o    = w_rd_ack;
   assign bus.raddr_o     = r_rptr_bin[ADDR_BITS-1:0];
   assign bus.rptr_bin_o  = r_rptr_bin;
   assign bus.rptr_gray_o = r_rptr_gray;
   assign bus.wptr_bin_o  = r_wptr_bin;
   assign bus.empty_o     = r_empty;
   assign bus.level_o     = r_level;

endmodule
`default_nettype wire
